// File: rtl/router_req_ctrl_if.sv
// router_req_ctrl_if: handshake bundle between one input buffer, the router's
// request controller and the five output arbiters.
// The master modport is the controller's view; slave is the environment's view.
interface router_req_ctrl_if #(
    parameter int FLIT_WIDTH = 34
);
    logic                  fin_valid_i;
    logic [FLIT_WIDTH-1:0] fin_data_i;
    logic                  fin_ready_o;
    logic [4:0]            req_o;
    logic [4:0]            grant_i;
    logic                  fout_valid_o;
    logic [FLIT_WIDTH-1:0] fout_data_o;
    logic                  fout_ready_i;
    logic                  busy_o;
    logic                  err_o;

    modport master (
        input  fin_valid_i, fin_data_i, grant_i, fout_ready_i,
        output fin_ready_o, req_o, fout_valid_o, fout_data_o, busy_o, err_o
    );

    modport slave (
        output fin_valid_i, fin_data_i, grant_i, fout_ready_i,
        input  fin_ready_o, req_o, fout_valid_o, fout_data_o, busy_o, err_o
    );
endinterface

// File: rtl/router_req_ctrl.sv
// router_req_ctrl: requester side of the per-output request/grant handshake,
// one instance per router input port. The head flit is routed in XY order by
// default; defining ROUTER_YX_ROUTING_EN switches to YX order. The one-hot
// request is held until the packet's tail has been forwarded (wormhole lock).
// Orphan body/tail flits seen while idle are popped and flagged on err_o.
module router_req_ctrl #(
    parameter int FLIT_WIDTH = 34,
    parameter int COLS       = 2,
    parameter int ROWS       = 2,
    parameter int COL_ADDR   = 0,
    parameter int ROW_ADDR   = 0
) (
    input  logic              clk,
    input  logic              arst,
    router_req_ctrl_if.master bus
);
    localparam int X_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int Y_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [31:0] COL_U = 32'(COL_ADDR);
    localparam logic [31:0] ROW_U = 32'(ROW_ADDR);

    localparam logic [4:0] DIR_LOCAL = 5'b00001;
    localparam logic [4:0] DIR_NORTH = 5'b00010;
    localparam logic [4:0] DIR_SOUTH = 5'b00100;
    localparam logic [4:0] DIR_WEST  = 5'b01000;
    localparam logic [4:0] DIR_EAST  = 5'b10000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t      state_q;
    logic [4:0]  req_q;

    logic [1:0]     flitType;
    logic           isHead;
    logic           isLast;
    logic [X_W-1:0] destX;
    logic [Y_W-1:0] destY;
    logic [31:0]    destXExt;
    logic [31:0]    destYExt;
    logic [4:0]     routeOneHot;
    logic           grantHit;
    logic           popInXfer;
    logic           tailDone;
    logic           orphan;

    // Decode the head-of-buffer flit: type and destination coordinates.
    assign flitType = bus.fin_data_i[FLIT_WIDTH-1 -: 2];
    assign isHead   = (flitType == 2'b00) || (flitType == 2'b11);
    assign isLast   = flitType[1];
    assign destX    = bus.fin_data_i[FLIT_WIDTH-3 -: X_W];
    assign destY    = bus.fin_data_i[FLIT_WIDTH-3-X_W -: Y_W];
    assign destXExt = 32'(destX);
    assign destYExt = 32'(destY);

    // Dimension-ordered route of the head flit, compared as unsigned 32-bit values.
    always_comb begin
        routeOneHot = DIR_LOCAL;
`ifdef ROUTER_YX_ROUTING_EN
        if (destYExt > ROW_U) begin
            routeOneHot = DIR_SOUTH;
        end else if (destYExt < ROW_U) begin
            routeOneHot = DIR_NORTH;
        end else if (destXExt > COL_U) begin
            routeOneHot = DIR_EAST;
        end else if (destXExt < COL_U) begin
            routeOneHot = DIR_WEST;
        end
`else
        if (destXExt > COL_U) begin
            routeOneHot = DIR_EAST;
        end else if (destXExt < COL_U) begin
            routeOneHot = DIR_WEST;
        end else if (destYExt > ROW_U) begin
            routeOneHot = DIR_SOUTH;
        end else if (destYExt < ROW_U) begin
            routeOneHot = DIR_NORTH;
        end
`endif
    end

    // Grant only counts on the output we actually requested; the pop is
    // gated by that grant so a dropped grant stalls without losing flits.
    assign grantHit  = |(bus.grant_i & req_q);
    assign popInXfer = (state_q == XFER) && grantHit && bus.fout_ready_i;
    assign tailDone  = popInXfer && bus.fin_valid_i && isLast;
    assign orphan    = arst && (state_q == IDLE) && bus.fin_valid_i && !isHead;

    // Request FSM: latch the route on a head, wait for grant, forward until tail.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q <= IDLE;
            req_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.fin_valid_i && isHead) begin
                        req_q   <= routeOneHot;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (grantHit) begin
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    if (tailDone) begin
                        req_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    req_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Handshake outputs; fout_valid_o deliberately ignores fout_ready_i.
    assign bus.req_o        = req_q;
    assign bus.fout_valid_o = (state_q == XFER) && bus.fin_valid_i && grantHit;
    assign bus.fin_ready_o  = orphan || popInXfer;
    assign bus.fout_data_o  = bus.fin_data_i;
    assign bus.busy_o       = (state_q != IDLE);
    assign bus.err_o        = orphan;
endmodule

// File: tb/tb_router_req_ctrl.sv
// tb_router_req_ctrl: self-checking bench for router_req_ctrl. A second
// instance on a 4x4 mesh at (1,2) exercises every routing direction.
module tb_router_req_ctrl;
    localparam int FW = 34;

    logic clk  = 1'b0;
    logic arst = 1'b0;
    logic arst2 = 1'b0;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [FW-1:0] pkt[$];
    logic [FW-1:0] outQ[$];
    int            popCyc[$];

    router_req_ctrl_if #(.FLIT_WIDTH(FW)) bus ();
    router_req_ctrl_if #(.FLIT_WIDTH(FW)) bus2 ();

    router_req_ctrl #(.FLIT_WIDTH(FW), .COLS(2), .ROWS(2), .COL_ADDR(0), .ROW_ADDR(0)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    router_req_ctrl #(.FLIT_WIDTH(FW), .COLS(4), .ROWS(4), .COL_ADDR(1), .ROW_ADDR(2)) dut2 (
        .clk  (clk),
        .arst (arst2),
        .bus  (bus2)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Abort guard in case something stalls outside the bounded loops.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Build a head-type flit with destination fields placed below the type bits.
    function automatic logic [FW-1:0] makeFlit(input logic [1:0] ft, input int dx, input int dy,
                                               input int xw, input int yw);
        logic [31:0] body;
        logic [31:0] mask;
        body = $urandom;
        mask = 32'hFFFF_FFFF >> (xw + yw);
        body = (body & mask) | (32'(dx) << (32 - xw)) | (32'(dy) << (32 - xw - yw));
        return {ft, body};
    endfunction

    function automatic logic [FW-1:0] randFlit(input logic [1:0] ft);
        logic [31:0] body;
        body = $urandom;
        return {ft, body};
    endfunction

    // Expected output direction from the signed distance to the destination.
    function automatic logic [4:0] routeModel(input int dx, input int dy, input int col, input int row);
        int ex;
        int ey;
        ex = dx - col;
        ey = dy - row;
`ifdef ROUTER_YX_ROUTING_EN
        if (ey != 0) return (ey > 0) ? 5'b00100 : 5'b00010;
        if (ex != 0) return (ex > 0) ? 5'b10000 : 5'b01000;
`else
        if (ex != 0) return (ex > 0) ? 5'b10000 : 5'b01000;
        if (ey != 0) return (ey > 0) ? 5'b00100 : 5'b00010;
`endif
        return 5'b00001;
    endfunction

    // Drive one cycle of inputs on the falling edge and let outputs settle.
    task automatic applyStimulus(input logic v, input logic [FW-1:0] d, input logic [4:0] g, input logic r);
        @(negedge clk);
        bus.fin_valid_i  = v;
        bus.fin_data_i   = d;
        bus.grant_i      = g;
        bus.fout_ready_i = r;
        #1;
    endtask

    // Push the packet in pkt through dut and check every cycle against the
    // handshake rules: request appears the cycle after the head is seen,
    // forwarding starts the cycle after a matching grant, and a flit leaves
    // exactly when valid, ready and grant coincide.
    task automatic runPacket(input string tag, input logic [4:0] expReq, input int grantDelay,
                             input int readyMode, input int validMode, input int dropMode);
        int cyc = 0;
        int idx = 0;
        int toggle = 0;
        bit granted = 1'b0;
        bit reqOn = 1'b0;
        bit done = 1'b0;
        logic v;
        logic r;
        logic g;
        logic [FW-1:0] d;
        logic [4:0] gnt;
        logic [4:0] other;
        outQ.delete();
        popCyc.delete();
        while (!done && cyc < 80) begin
            v = (cyc == 0 || validMode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            d = v ? pkt[idx] : randFlit(2'($urandom));
            other = 5'($urandom) & ~expReq;
            if (cyc >= 1 + grantDelay || grantDelay == 0) begin
                if (granted && dropMode != 0 && $urandom_range(0, 3) == 0) gnt = other;
                else gnt = expReq | other;
            end else begin
                gnt = other;
            end
            case (readyMode)
                0: r = 1'b1;
                1: r = (toggle % 2 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            applyStimulus(v, d, gnt, r);
            g = |(gnt & expReq);

            testsRun++;
            if (bus.req_o !== (reqOn ? expReq : 5'b0)) begin
                testsFailed++;
                $display("[TB] FAIL %s req_o cyc%0d: got %b want %b", tag, cyc, bus.req_o, reqOn ? expReq : 5'b0);
            end
            testsRun++;
            if (bus.fout_valid_o !== (granted && v && g)) begin
                testsFailed++;
                $display("[TB] FAIL %s fout_valid_o cyc%0d: got %b want %b", tag, cyc, bus.fout_valid_o, granted && v && g);
            end
            testsRun++;
            if (bus.fin_ready_o !== (granted && r && g)) begin
                testsFailed++;
                $display("[TB] FAIL %s fin_ready_o cyc%0d: got %b want %b", tag, cyc, bus.fin_ready_o, granted && r && g);
            end
            testsRun++;
            if (bus.busy_o !== reqOn) begin
                testsFailed++;
                $display("[TB] FAIL %s busy_o cyc%0d: got %b want %b", tag, cyc, bus.busy_o, reqOn);
            end
            testsRun++;
            if (bus.err_o !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL %s err_o cyc%0d: got %b want 0", tag, cyc, bus.err_o);
            end
            if (v) begin
                testsRun++;
                if (bus.fout_data_o !== d) begin
                    testsFailed++;
                    $display("[TB] FAIL %s fout_data_o cyc%0d: got %h want %h", tag, cyc, bus.fout_data_o, d);
                end
            end

            if (granted && v && r && g) begin
                outQ.push_back(bus.fout_data_o);
                popCyc.push_back(cyc);
                idx++;
                if (idx == pkt.size()) done = 1'b1;
            end
            if (granted) toggle++;
            if (reqOn && !granted && g) granted = 1'b1;
            if (cyc == 0) reqOn = 1'b1;
            cyc++;
        end
        if (!done) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s timeout: %0d of %0d flits forwarded", tag, idx, pkt.size());
        end

        applyStimulus(1'b0, '0, expReq, 1'b1);
        testsRun++;
        if (bus.req_o !== 5'b0 || bus.busy_o !== 1'b0 || bus.fout_valid_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL %s after tail: req_o=%b busy_o=%b fout_valid_o=%b want 00000/0/0",
                     tag, bus.req_o, bus.busy_o, bus.fout_valid_o);
        end
        testsRun++;
        if (outQ.size() != pkt.size()) begin
            testsFailed++;
            $display("[TB] FAIL %s flit count: got %0d want %0d", tag, outQ.size(), pkt.size());
        end else begin
            for (int i = 0; i < pkt.size(); i++) begin
                testsRun++;
                if (outQ[i] !== pkt[i]) begin
                    testsFailed++;
                    $display("[TB] FAIL %s flit %0d: got %h want %h", tag, i, outQ[i], pkt[i]);
                end
            end
        end
    endtask

    // Outputs stay quiet during reset, even with a body flit offered, and after release.
    task automatic test_reset;
        @(negedge clk);
        arst = 1'b0;
        bus.fin_valid_i  = 1'b1;
        bus.fin_data_i   = randFlit(2'b01);
        bus.grant_i      = 5'b11111;
        bus.fout_ready_i = 1'b1;
        #1;
        testsRun++;
        if ({bus.req_o, bus.fout_valid_o, bus.fin_ready_o, bus.busy_o, bus.err_o} !== 9'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_hold: req=%b fv=%b fr=%b busy=%b err=%b want all 0",
                     bus.req_o, bus.fout_valid_o, bus.fin_ready_o, bus.busy_o, bus.err_o);
        end
        @(negedge clk);
        arst = 1'b1;
        bus.fin_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, randFlit(2'b00), 5'b11111, 1'b1);
            testsRun++;
            if (bus.req_o !== 5'b0 || bus.fout_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL reset_idle cyc%0d: req=%b fv=%b busy=%b want 00000/0/0",
                         i, bus.req_o, bus.fout_valid_o, bus.busy_o);
            end
        end
    endtask

    // Three-flit packet to (1,0) with grant held: flits leave in cycles 2..4.
    task automatic test_xy_packet;
        pkt.delete();
        pkt.push_back(makeFlit(2'b00, 1, 0, 1, 1));
        pkt.push_back(randFlit(2'b01));
        pkt.push_back(randFlit(2'b10));
        runPacket("xy_packet", routeModel(1, 0, 0, 0), 0, 0, 0, 0);
        testsRun++;
        if (popCyc.size() != 3 || popCyc[0] != 2 || popCyc[1] != 3 || popCyc[2] != 4) begin
            testsFailed++;
            $display("[TB] FAIL xy_packet timing: got %0d pops first at %0d want 3 pops at 2,3,4",
                     popCyc.size(), (popCyc.size() > 0) ? popCyc[0] : -1);
        end
    endtask

    // Single-flit packet to (0,1); the matching grant comes 4 cycles late.
    task automatic test_grant_wait;
        pkt.delete();
        pkt.push_back(makeFlit(2'b11, 0, 1, 1, 1));
        runPacket("grant_wait", routeModel(0, 1, 0, 0), 4, 0, 0, 0);
        testsRun++;
        if (popCyc.size() != 1 || popCyc[0] != 6) begin
            testsFailed++;
            $display("[TB] FAIL grant_wait timing: got %0d pops first at %0d want 1 pop at 6",
                     popCyc.size(), (popCyc.size() > 0) ? popCyc[0] : -1);
        end
    endtask

    // Four-flit packet to (1,1) with fout_ready_i alternating 1,0,1,0; a
    // mid-packet HEAD-typed flit must pass through as plain data.
    task automatic test_ready_toggle;
        pkt.delete();
        pkt.push_back(makeFlit(2'b00, 1, 1, 1, 1));
        pkt.push_back(randFlit(2'b01));
        pkt.push_back(randFlit(2'b00));
        pkt.push_back(randFlit(2'b10));
        runPacket("ready_toggle", routeModel(1, 1, 0, 0), 0, 1, 0, 0);
        testsRun++;
        if (popCyc.size() != 4 || popCyc[0] != 2 || popCyc[1] != 4 || popCyc[2] != 6 || popCyc[3] != 8) begin
            testsFailed++;
            $display("[TB] FAIL ready_toggle timing: got %0d pops last at %0d want 4 pops at 2,4,6,8",
                     popCyc.size(), (popCyc.size() > 0) ? popCyc[popCyc.size()-1] : -1);
        end
    endtask

    // Body and tail flits seen while idle are popped with a one-cycle err_o.
    task automatic test_orphan;
        logic [1:0] types [2];
        types[0] = 2'b01;
        types[1] = 2'b10;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, randFlit(types[i]), 5'b11111, 1'b1);
            testsRun++;
            if (bus.fin_ready_o !== 1'b1 || bus.err_o !== 1'b1 || bus.req_o !== 5'b0 || bus.busy_o !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL orphan type%0d: fr=%b err=%b req=%b busy=%b want 1/1/00000/0",
                         types[i], bus.fin_ready_o, bus.err_o, bus.req_o, bus.busy_o);
            end
            applyStimulus(1'b0, randFlit(types[i]), 5'b11111, 1'b1);
            testsRun++;
            if (bus.err_o !== 1'b0 || bus.fin_ready_o !== 1'b0 || bus.busy_o !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL orphan_after type%0d: err=%b fr=%b busy=%b want 0/0/0",
                         types[i], bus.err_o, bus.fin_ready_o, bus.busy_o);
            end
        end
    endtask

    // Reset pulsed after head and body are forwarded: request drops at once,
    // and the leftover tail is dropped as an orphan.
    task automatic test_reset_mid_packet;
        logic [FW-1:0] head;
        logic [FW-1:0] tail;
        head = makeFlit(2'b00, 1, 0, 1, 1);
        tail = randFlit(2'b10);
        applyStimulus(1'b1, head, 5'b10000, 1'b1);
        applyStimulus(1'b1, head, 5'b10000, 1'b1);
        applyStimulus(1'b1, head, 5'b10000, 1'b1);
        applyStimulus(1'b1, randFlit(2'b01), 5'b10000, 1'b1);
        testsRun++;
        if (bus.req_o !== 5'b10000 || bus.fout_valid_o !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL midreset_pre: req=%b fv=%b want 10000/1", bus.req_o, bus.fout_valid_o);
        end
        @(negedge clk);
        bus.fin_data_i = tail;
        arst = 1'b0;
        #1;
        testsRun++;
        if (bus.req_o !== 5'b0 || bus.busy_o !== 1'b0 || bus.fout_valid_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_drop: req=%b busy=%b fv=%b want 00000/0/0",
                     bus.req_o, bus.busy_o, bus.fout_valid_o);
        end
        #1;
        arst = 1'b1;
        #1;
        testsRun++;
        if (bus.err_o !== 1'b1 || bus.fin_ready_o !== 1'b1 || bus.req_o !== 5'b0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_tail: err=%b fr=%b req=%b want 1/1/00000",
                     bus.err_o, bus.fin_ready_o, bus.req_o);
        end
        applyStimulus(1'b0, '0, 5'b10000, 1'b1);
        testsRun++;
        if (bus.err_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_after: err=%b busy=%b want 0/0", bus.err_o, bus.busy_o);
        end
    endtask

    // Every destination of the 4x4 mesh seen from router (1,2).
    task automatic test_routing;
        logic [4:0] want;
        bus2.grant_i      = 5'b0;
        bus2.fout_ready_i = 1'b0;
        for (int dx = 0; dx < 4; dx++) begin
            for (int dy = 0; dy < 4; dy++) begin
                want = routeModel(dx, dy, 1, 2);
                @(negedge clk);
                arst2 = 1'b0;
                bus2.fin_valid_i = 1'b1;
                bus2.fin_data_i  = makeFlit(2'b00, dx, dy, 2, 2);
                #1;
                arst2 = 1'b1;
                #1;
                testsRun++;
                if (bus2.req_o !== 5'b0 || bus2.fin_ready_o !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL route_idle (%0d,%0d): req=%b fr=%b want 00000/0",
                             dx, dy, bus2.req_o, bus2.fin_ready_o);
                end
                @(negedge clk);
                #1;
                testsRun++;
                if (bus2.req_o !== want || bus2.busy_o !== 1'b1) begin
                    testsFailed++;
                    $display("[TB] FAIL route (%0d,%0d): req=%b busy=%b want %b/1",
                             dx, dy, bus2.req_o, bus2.busy_o, want);
                end
                bus2.fin_valid_i = 1'b0;
            end
        end
    endtask

    // Random packets: lengths, destinations, grant delay/drops, valid gaps and ready.
    task automatic test_random;
        int len;
        int dx;
        int dy;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 4);
            dx  = $urandom_range(0, 1);
            dy  = $urandom_range(0, 1);
            pkt.delete();
            if (len == 1) begin
                pkt.push_back(makeFlit(2'b11, dx, dy, 1, 1));
            end else begin
                pkt.push_back(makeFlit(2'b00, dx, dy, 1, 1));
                for (int k = 1; k < len - 1; k++) pkt.push_back(randFlit(2'($urandom_range(0, 1))));
                pkt.push_back(randFlit(2'b10));
            end
            runPacket("random", routeModel(dx, dy, 0, 0), $urandom_range(0, 3), 2, 1, 1);
        end
    endtask

    // Run all scenarios in order, then report.
    initial begin
        bus.fin_valid_i   = 1'b0;
        bus.fin_data_i    = '0;
        bus.grant_i       = 5'b0;
        bus.fout_ready_i  = 1'b0;
        bus2.fin_valid_i  = 1'b0;
        bus2.fin_data_i   = '0;
        bus2.grant_i      = 5'b0;
        bus2.fout_ready_i = 1'b0;
        test_reset;
        test_xy_packet;
        test_grant_wait;
        test_ready_toggle;
        test_orphan;
        test_reset_mid_packet;
        test_routing;
        test_random;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/router_req_ctrl.md
Name: router_req_ctrl

Overview:
- Requester side of the router's per-output request/grant handshake; one instance per input port.
- Peeks the head flit of the input buffer, computes the output direction with dimension-ordered routing, and raises a one-hot request towards the five output arbiters.
- Holds the request until the packet's tail flit has been forwarded, so the output stays locked for the whole wormhole packet.

Parameters:
- FLIT_WIDTH, 34, flit width in bits; [FLIT_WIDTH-1:FLIT_WIDTH-2] is the flit type.
- COLS, 2, mesh columns; X_W = max(1, $clog2(COLS)).
- ROWS, 2, mesh rows; Y_W = max(1, $clog2(ROWS)).
- COL_ADDR, 0, this router's column (x).
- ROW_ADDR, 0, this router's row (y).

Ports:
- clk, input, 1, single clock.
- arst, input, 1, asynchronous active-low reset.
- fin_valid_i, input, 1, input buffer holds a flit.
- fin_data_i, input, FLIT_WIDTH, flit at the input buffer head.
- fin_ready_o, output, 1, pops the input buffer.
- req_o, output, 5, one-hot request: bit0 LOCAL, bit1 NORTH, bit2 SOUTH, bit3 WEST, bit4 EAST.
- grant_i, input, 5, grant vector from the output arbiters.
- fout_valid_o, output, 1, flit valid towards the granted output.
- fout_data_o, output, FLIT_WIDTH, forwarded flit (combinational pass of fin_data_i).
- fout_ready_i, input, 1, granted output accepts the flit.
- busy_o, output, 1, packet in flight (state != IDLE).
- err_o, output, 1, one-cycle pulse when an orphan body/tail flit is dropped.

Behaviour:
- Flit type encoding: 00 HEAD, 01 BODY, 10 TAIL, 11 HEAD_TAIL (single-flit packet).
- Head field layout: dest_x = fin_data_i[FLIT_WIDTH-3 -: X_W]; dest_y = the next Y_W bits below dest_x.
- Reset (arst=0, asynchronous): state=IDLE, req_q=0. Outputs: req_o=0, fout_valid_o=0, fin_ready_o=0, busy_o=0, err_o=0.
- Routing, XY order (row index grows southward):
  - dest_x>COL_ADDR → EAST; dest_x<COL_ADDR → WEST.
  - Otherwise dest_y>ROW_ADDR → SOUTH; dest_y<ROW_ADDR → NORTH.
  - Otherwise LOCAL.
  - Compare unsigned; X_W/Y_W-bit fields are zero-extended to 32 bits before comparing.
- FSM states: IDLE, REQ, XFER.
- IDLE:
  - fin_valid_i with HEAD/HEAD_TAIL: register req_q = route one-hot, go to REQ. The flit is not popped (fin_ready_o=0).
  - fin_valid_i with BODY/TAIL: fin_ready_o=1 (drop the flit), err_o=1 for that cycle, stay in IDLE.
- REQ:
  - req_o = req_q. fin_ready_o=0, fout_valid_o=0.
  - |(grant_i & req_q) → XFER on the next edge; otherwise wait indefinitely, holding req_o stable.
- XFER:
  - req_o = req_q. Let g = |(grant_i & req_q).
  - fout_valid_o = fin_valid_i & g; fin_ready_o = fout_ready_i & g.
  - A transfer occurs when fin_valid_i & fin_ready_o.
  - Transfer of TAIL or HEAD_TAIL: req_q cleared, return to IDLE; req_o is 0 the following cycle.
  - If grant drops mid-packet (g=0): stall without dropping any flit; req_o stays asserted.
  - A HEAD flit arriving in XFER is forwarded as data and does not re-route.
- Latency: head visible at cycle 0 → req_o at cycle 1 → head forwarded at cycle 2 at the earliest (same-cycle grant). Single-flit packet: minimum 3 cycles per packet, including the return through IDLE.
- req_o is only ever one-hot or zero; it never changes between REQ entry and tail acceptance.
- fout_valid_o must not depend combinationally on fout_ready_i.
- Reset mid-packet: req_o drops immediately. Remaining body/tail flits of that packet are then dropped with an err_o pulse each.

Optional Feature:
- Macro: ROUTER_YX_ROUTING_EN.
- Defined: route in YX order (compare dest_y first → NORTH/SOUTH, then dest_x → WEST/EAST, else LOCAL). All else unchanged.
- Undefined: XY order as above.

Test Plan:
- Reset release, fin_valid_i=0 for 5 cycles → req_o=0, fout_valid_o=0, busy_o=0 throughout.
- COL_ADDR=0, ROW_ADDR=0; HEAD dest (1,0) + BODY + TAIL; grant_i=5'b10000 held → req_o=5'b10000 from cycle 1. Three flits forwarded in cycles 2-4 bit-exact; req_o=0 at cycle 5.
- HEAD_TAIL dest (0,1), grant withheld 4 cycles then granted → req_o=5'b00100 stable while waiting, fout_valid_o=0 while waiting, one flit out, then IDLE.
- XFER with fout_ready_i toggling 1,0,1,0 on a 4-flit packet → no flit lost or duplicated; fin_ready_o mirrors fout_ready_i.
- BODY flit presented in IDLE → popped, err_o high for exactly one cycle, req_o=0.
- arst pulsed low mid-packet → req_o=0 immediately; the next TAIL is dropped with err_o=1. With ROUTER_YX_ROUTING_EN, a HEAD with dest (1,1) gives req_o=5'b00100 instead of 5'b10000.
